// File: rtl/unary_pkg.sv
// Shared definitions for the unary datapath (encoder, adders, counters).
package unary_pkg;

  // Default binary operand width; a frame is 2^DefaultWidth serial bits.
  localparam int unsigned DefaultWidth = 7;
  localparam int unsigned FrameLen     = 1 << DefaultWidth;

  // Frame sequencer states.
  typedef enum logic {
    StIdle,
    StEmit
  } unary_state_e;

  // Bit-ordering select.
  localparam logic ModeTherm  = 1'b0;
  localparam logic ModeSpread = 1'b1;

  // Thermometer rule: frame bit idx is set iff it lies below the value.
  function automatic logic therm_bit(input logic [DefaultWidth-1:0] idx,
                                     input logic [DefaultWidth-1:0] val);
    return idx < val;
  endfunction

endpackage

// File: rtl/unary_bit_gen.sv
// Combinational frame-bit generator: thermometer comparator or spread accumulator.
module unary_bit_gen
  import unary_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic [Width-1:0] val_i,
  input  logic             mode_i,
  input  logic [Width-1:0] cnt_i,
  input  logic [Width-1:0] acc_i,
  output logic             bit_o,
  output logic [Width-1:0] acc_o
);

  logic [Width:0] sum;

  // Spread mode emits the accumulator carry, spacing val ones evenly over the frame.
  always_comb begin
    sum   = {1'b0, acc_i} + {1'b0, val_i};
    bit_o = 1'b0;
    acc_o = acc_i;
    if (mode_i == ModeSpread) begin
      bit_o = sum[Width];
      acc_o = sum[Width-1:0];
    end else begin
      bit_o = cnt_i < val_i;
    end
  end

endmodule

// File: rtl/unary_stream_encoder.sv
// Binary-to-unary serial encoder: one 2^Width-bit frame per load, with busy/done handshake.
module unary_stream_encoder
  import unary_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] din_i,
  input  logic             mode_i,
  output logic             dout_o,
  output logic             busy_o,
  output logic             done_o
);

  unary_state_e     state_q;
  logic [Width-1:0] val_q;
  logic             m_q;
  logic [Width-1:0] cnt_q;
  logic [Width-1:0] acc_q;
  logic             dout_q;
  logic             busy_q;
  logic             done_q;

  logic             gen_bit;
  logic [Width-1:0] gen_acc;
  logic             cnt_last;

  unary_bit_gen #(
    .Width (Width)
  ) u_bit_gen (
    .val_i  (val_q),
    .mode_i (m_q),
    .cnt_i  (cnt_q),
    .acc_i  (acc_q),
    .bit_o  (gen_bit),
    .acc_o  (gen_acc)
  );

  // Final bit of the frame is the one emitted at the all-ones count.
  always_comb begin
    cnt_last = &cnt_q;
  end

  // Frame sequencer with registered outputs; a stall holds cnt/acc and blanks dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val_q   <= '0;
      m_q     <= ModeTherm;
      cnt_q   <= '0;
      acc_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dout_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (en_i && load_i) begin
            val_q   <= din_i;
            m_q     <= mode_i;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= StEmit;
          end
        end
        StEmit: begin
          busy_q <= 1'b1;
          if (en_i) begin
            dout_q <= gen_bit;
            acc_q  <= gen_acc;
            cnt_q  <= cnt_q + Width'(1);
            if (cnt_last) begin
              done_q <= 1'b1;
              if (load_i) begin
                // Back-to-back: next frame's bit 0 follows on the very next edge.
                val_q <= din_i;
                m_q   <= mode_i;
                acc_q <= '0;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout_o = dout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
